// File: rtl/axil_memory_arbiter_if.sv
// AXI4-Lite bundle without the read response field. It is used for both the
// requester ports and the shared-memory port of the memory arbiter.
interface axil_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_memory_arbiter.sv
// Round-robin arbiter for instruction-fetch reads, data reads and data writes.
// It shares one AXI4-Lite memory port and allows one outstanding transaction.
module axil_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_N,
  axil_memory_arbiter_if.slave  s_imem_axil,
  axil_memory_arbiter_if.slave  s_dmem_axil,
  axil_memory_arbiter_if.master m_axil,
  output logic                  o_Busy,
  output logic [1:0]            o_Grant
);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AWW, ST_B} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I_RD = 2'b01;
  localparam logic [1:0] GNT_D_RD = 2'b10;
  localparam logic [1:0] GNT_D_WR = 2'b11;

  state_t                  state_reg, state_next;
  logic [1:0]              grant_reg, grant_next;
  logic [1:0]              last_reg, last_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
  logic                    aw_done_reg, aw_done_next;
  logic                    w_done_reg, w_done_next;

  logic [1:0] pick;
  logic       req_i_rd, req_d_rd, req_d_wr;
  logic       slave_rready;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic unused_imem_write;
  assign unused_imem_write = ^{s_imem_axil.awaddr, s_imem_axil.awvalid, s_imem_axil.wdata,
                               s_imem_axil.wstrb, s_imem_axil.wvalid, s_imem_axil.bready};

  assign req_i_rd = s_imem_axil.arvalid;
  assign req_d_rd = s_dmem_axil.arvalid;
  assign req_d_wr = s_dmem_axil.awvalid && s_dmem_axil.wvalid;

  assign slave_rready = (grant_reg == GNT_I_RD) ? s_imem_axil.rready : s_dmem_axil.rready;
  assign ar_hs = (state_reg == ST_AR) && m_axil.arready;
  assign r_hs  = (state_reg == ST_R) && m_axil.rvalid && slave_rready;
  assign aw_hs = (state_reg == ST_AWW) && !aw_done_reg && m_axil.awready;
  assign w_hs  = (state_reg == ST_AWW) && !w_done_reg && m_axil.wready;
  assign b_hs  = (state_reg == ST_B) && m_axil.bvalid && s_dmem_axil.bready;

  // The search starts at the requester that follows the last one granted.
  always_comb begin
    pick = GNT_NONE;
    case (last_reg)
      GNT_I_RD: begin
        if (req_d_rd)      pick = GNT_D_RD;
        else if (req_d_wr) pick = GNT_D_WR;
        else if (req_i_rd) pick = GNT_I_RD;
      end
      GNT_D_RD: begin
        if (req_d_wr)      pick = GNT_D_WR;
        else if (req_i_rd) pick = GNT_I_RD;
        else if (req_d_rd) pick = GNT_D_RD;
      end
      default: begin
        if (req_i_rd)      pick = GNT_I_RD;
        else if (req_d_rd) pick = GNT_D_RD;
        else if (req_d_wr) pick = GNT_D_WR;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= GNT_NONE;
      last_reg    <= GNT_D_WR;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_next   = pick;
          last_next    = pick;
          wdata_next   = s_dmem_axil.wdata;
          wstrb_next   = s_dmem_axil.wstrb;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          if (pick == GNT_I_RD)      addr_next = s_imem_axil.araddr;
          else if (pick == GNT_D_RD) addr_next = s_dmem_axil.araddr;
          else                       addr_next = s_dmem_axil.awaddr;
          state_next = (pick == GNT_D_WR) ? ST_AWW : ST_AR;
        end
      end
      ST_AR: if (ar_hs) state_next = ST_R;
      ST_R:  if (r_hs) state_next = ST_IDLE;
      ST_AWW: begin
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg || w_hs;
        if (aw_done_next && w_done_next) state_next = ST_B;
      end
      ST_B:    if (b_hs) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Read data and response fields are passed through ungated. The valids and readies are what qualify them.
  always_comb begin
    m_axil.araddr        = addr_reg;
    m_axil.awaddr        = addr_reg;
    m_axil.wdata         = wdata_reg;
    m_axil.wstrb         = wstrb_reg;
    m_axil.arvalid       = 1'b0;
    m_axil.rready        = 1'b0;
    m_axil.awvalid       = 1'b0;
    m_axil.wvalid        = 1'b0;
    m_axil.bready        = 1'b0;
    s_imem_axil.arready  = 1'b0;
    s_imem_axil.rvalid   = 1'b0;
    s_imem_axil.rdata    = m_axil.rdata;
    s_imem_axil.awready  = 1'b0;
    s_imem_axil.wready   = 1'b0;
    s_imem_axil.bvalid   = 1'b0;
    s_imem_axil.bresp    = 2'b00;
    s_dmem_axil.arready  = 1'b0;
    s_dmem_axil.rvalid   = 1'b0;
    s_dmem_axil.rdata    = m_axil.rdata;
    s_dmem_axil.awready  = 1'b0;
    s_dmem_axil.wready   = 1'b0;
    s_dmem_axil.bvalid   = 1'b0;
    s_dmem_axil.bresp    = m_axil.bresp;
    o_Busy               = (state_reg != ST_IDLE);
    o_Grant              = (state_reg == ST_IDLE) ? GNT_NONE : grant_reg;
    case (state_reg)
      ST_AR: begin
        m_axil.arvalid = 1'b1;
        if (grant_reg == GNT_I_RD) s_imem_axil.arready = m_axil.arready;
        else                       s_dmem_axil.arready = m_axil.arready;
      end
      ST_R: begin
        m_axil.rready = slave_rready;
        if (grant_reg == GNT_I_RD) s_imem_axil.rvalid = m_axil.rvalid;
        else                       s_dmem_axil.rvalid = m_axil.rvalid;
      end
      ST_AWW: begin
        m_axil.awvalid      = !aw_done_reg;
        m_axil.wvalid       = !w_done_reg;
        s_dmem_axil.awready = !aw_done_reg && m_axil.awready;
        s_dmem_axil.wready  = !w_done_reg && m_axil.wready;
      end
      ST_B: begin
        m_axil.bready      = s_dmem_axil.bready;
        s_dmem_axil.bvalid = m_axil.bvalid;
      end
      default: ;
    endcase
  end

endmodule
